grid_mem_arbiter: RTL

GRID_MEM_ARBITER -- requirements
Module: grid_mem_arbiter

---
 rtl/grid_mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter
//   Owns a GRID_SIZE x GRID_SIZE single-bit cell grid and arbitrates its one
//   access per cycle between three users, in fixed priority:
//     1. renderer    : registered read, data one cycle after vga_rd_en
//     2. clear engine: row-major sweep writing 1 on the border, 0 inside
//     3. game FSM    : read or atomic test-and-set write, old value returned
//
// Ports
//   clk, reset_n                   clock, asynchronous active-low reset
//   vga_rd_en, vga_x, vga_y        renderer read request and cell address
//   vga_rd_data                    renderer read data (0 after an idle cycle)
//   game_req, game_we              game request (held until grant), 1 = write
//   game_x, game_y, game_wdata     game cell address and write value
//   game_gnt                       high in the cycle the game access executes
//   game_rdata, game_rvalid        pre-access cell value, pulse qualifier
//   clr_start                      start a grid initialisation sweep
//   clr_busy, clr_done             sweep in progress / completion pulse
module grid_mem_arbiter #(
  parameter int GRID_SIZE     = 32,
  parameter int LOG_GRID_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vga_rd_en,
  input  logic [LOG_GRID_SIZE-1:0] vga_x,
  input  logic [LOG_GRID_SIZE-1:0] vga_y,
  output logic                     vga_rd_data,
  input  logic                     game_req,
  input  logic                     game_we,
  input  logic [LOG_GRID_SIZE-1:0] game_x,
  input  logic [LOG_GRID_SIZE-1:0] game_y,
  input  logic                     game_wdata,
  output logic                     game_gnt,
  output logic                     game_rdata,
  output logic                     game_rvalid,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int CELLS  = GRID_SIZE * GRID_SIZE;
  localparam int ADDR_W = 2 * LOG_GRID_SIZE;
  localparam logic [LOG_GRID_SIZE-1:0] LAST = LOG_GRID_SIZE'(GRID_SIZE - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                   state;
  logic [LOG_GRID_SIZE-1:0] clr_x;
  logic [LOG_GRID_SIZE-1:0] clr_y;
  logic                     clr_write;
  logic [ADDR_W-1:0]        vga_addr;
  logic [ADDR_W-1:0]        game_addr;
  logic [ADDR_W-1:0]        clr_addr;

  // Contents are deliberately not reset; only a completed sweep defines them.
  logic grid [CELLS];

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [LOG_GRID_SIZE-1:0] x,
                                                  input logic [LOG_GRID_SIZE-1:0] y);
    return ADDR_W'(y) * ADDR_W'(GRID_SIZE) + ADDR_W'(x);
  endfunction

  function automatic logic is_border(input logic [LOG_GRID_SIZE-1:0] x,
                                     input logic [LOG_GRID_SIZE-1:0] y);
    return (x == '0) || (x == LAST) || (y == '0) || (y == LAST);
  endfunction

  assign vga_addr  = cell_addr(vga_x, vga_y);
  assign game_addr = cell_addr(game_x, game_y);
  assign clr_addr  = cell_addr(clr_x, clr_y);

  // The sweep only uses cycles the renderer leaves free.
  assign clr_write = (state == CLEAR) && !vga_rd_en;

  // Game grant: lowest priority. game_rvalid high means a grant happened last
  // cycle, which enforces the one-grant-per-two-cycles spacing. The clr_done
  // cycle is also excluded so a request parked behind a sweep is served
  // strictly after the completion pulse. reset_n gating keeps the pulse low
  // while reset is held.
  assign game_gnt = reset_n && game_req && !vga_rd_en && !clr_busy &&
                    !clr_done && !game_rvalid;

  // Clear controller: IDLE/CLEAR with registered busy/done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      clr_x    <= '0;
      clr_y    <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            clr_x    <= '0;
            clr_y    <= '0;
          end
        end
        CLEAR: begin
          // clr_start is ignored here; the sweep is never restarted.
          if (!vga_rd_en) begin
            if (clr_x == LAST) begin
              clr_x <= '0;
              if (clr_y == LAST) begin
                clr_y    <= '0;
                state    <= IDLE;
                clr_busy <= 1'b0;
                clr_done <= 1'b1;
              end else begin
                clr_y <= clr_y + 1'b1;
              end
            end else begin
              clr_x <= clr_x + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read responses: renderer data and the game's pre-access value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_rd_data <= 1'b0;
      game_rdata  <= 1'b0;
      game_rvalid <= 1'b0;
    end else begin
      vga_rd_data <= vga_rd_en ? grid[vga_addr] : 1'b0;
      game_rvalid <= game_gnt;
      if (game_gnt) begin
        game_rdata <= grid[game_addr];
      end
    end
  end

  // Cell writes: sweep and game grants never coincide (grant needs !clr_busy).
  always_ff @(posedge clk) begin
    if (clr_write) begin
      grid[clr_addr] <= is_border(clr_x, clr_y);
    end else if (game_gnt && game_we) begin
      grid[game_addr] <= game_wdata;
    end
  end

endmodule
